// File: rtl/tlb_l2_ctrl.sv
// ----------------------------------------------------------------------------
// tlb_l2_ctrl
//
// Purpose:
//    Sequencer and arbiter in front of the shared set-associative L2 TLB.
//    Accepts miss requests from the ITLB and DTLB, starts the L2 hash-rehash
//    lookup and returns hits. On an L2 miss the request is handed to the
//    page-table walker, and the walk result is written back into the L2 TLB.
//    Only one request is in flight at a time.
//
// Ports:
//    clk_i, rst_ni              clock, synchronous active-low reset
//    flush_i                    SFENCE flush (same pulse the L2 TLB sees)
//    itlb_* / dtlb_*            request (level, held until granted), vaddr,
//                               ASID, combinational grant, response pulse
//    resp_*                     shared response: PTE, page size, walk fault
//    lu_*                       L2 TLB lookup start/address and status
//    update_o                   L2 TLB refill after a successful walk
//    ptw_*                      page-table walker request and result
// ----------------------------------------------------------------------------

package tlb_l2_pkg;
   localparam int unsigned VLEN     = 39;
   // The refill ASID field is sized for the widest ASID the L2 may use; the
   // controller fills the low ASID_WIDTH bits and leaves the rest zero.
   localparam int unsigned ASID_MAX = 16;

   typedef logic [63:0] pte_t;

   typedef struct packed {
      logic                valid;
      logic                is_2M;
      logic                is_1G;
      logic [26:0]         vpn;
      logic [ASID_MAX-1:0] asid;
      pte_t                content;
   } tlb_update_t;
endpackage

module tlb_l2_ctrl
   import tlb_l2_pkg::*;
#(
   parameter int unsigned ASID_WIDTH = 1,
   parameter bit          DTLB_PRIO  = 1'b0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  itlb_req_i,
   input  logic [VLEN-1:0]       itlb_vaddr_i,
   input  logic [ASID_WIDTH-1:0] itlb_asid_i,
   input  logic                  dtlb_req_i,
   input  logic [VLEN-1:0]       dtlb_vaddr_i,
   input  logic [ASID_WIDTH-1:0] dtlb_asid_i,
   output logic                  itlb_gnt_o,
   output logic                  dtlb_gnt_o,
   output logic                  itlb_resp_valid_o,
   output logic                  dtlb_resp_valid_o,
   output pte_t                  resp_content_o,
   output logic                  resp_is_2M_o,
   output logic                  resp_is_1G_o,
   output logic                  resp_error_o,
   output logic                  lu_access_o,
   output logic [VLEN-1:0]       lu_vaddr_o,
   output logic [ASID_WIDTH-1:0] lu_asid_o,
   input  logic                  lu_hit_i,
   input  logic                  lu_is_2M_i,
   input  logic                  lu_is_1G_i,
   input  logic                  all_hashes_checked_i,
   input  pte_t                  lu_content_i,
   output tlb_update_t           update_o,
   output logic                  ptw_req_o,
   output logic [VLEN-1:0]       ptw_vaddr_o,
   output logic [ASID_WIDTH-1:0] ptw_asid_o,
   input  logic                  ptw_valid_i,
   input  logic                  ptw_error_i,
   input  pte_t                  ptw_content_i,
   input  logic                  ptw_is_2M_i,
   input  logic                  ptw_is_1G_i
);

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      WALK,
      RESP
   } state_e;

   state_e                state_q;
   logic                  kill_q;
   logic                  rr_dtlb_q;
   logic                  req_dtlb_q;
   logic                  first_lu_q;
   logic                  from_walk_q;
   logic                  err_q;
   logic                  is_2M_q;
   logic                  is_1G_q;
   logic [VLEN-1:0]       vaddr_q;
   logic [ASID_WIDTH-1:0] asid_q;
   pte_t                  content_q;

   logic grant_en;
   logic pick_dtlb;
   logic any_gnt;
   logic resp_fire;

   // Arbitration is only open in IDLE and never while a flush is pending.
   // The DTLB wins when it is alone, when fixed priority is selected, or when
   // the round-robin pointer says the ITLB was served last.
   always_comb begin
      grant_en   = (state_q == IDLE) && !flush_i;
      pick_dtlb  = dtlb_req_i && (!itlb_req_i || DTLB_PRIO || rr_dtlb_q);
      any_gnt    = grant_en && (itlb_req_i || dtlb_req_i);
      itlb_gnt_o = grant_en && itlb_req_i && !pick_dtlb;
      dtlb_gnt_o = grant_en && pick_dtlb;
   end

   // Main sequencer. A flush seen during the lookup or the walk only marks
   // the transaction as killed: the L2 hash sequence and the walker are always
   // allowed to finish so their internal state stays consistent, and the
   // result is then silently dropped in RESP.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         kill_q      <= 1'b0;
         rr_dtlb_q   <= 1'b0;
         req_dtlb_q  <= 1'b0;
         first_lu_q  <= 1'b0;
         from_walk_q <= 1'b0;
         err_q       <= 1'b0;
         is_2M_q     <= 1'b0;
         is_1G_q     <= 1'b0;
         vaddr_q     <= '0;
         asid_q      <= '0;
         content_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_gnt) begin
                  vaddr_q    <= pick_dtlb ? dtlb_vaddr_i : itlb_vaddr_i;
                  asid_q     <= pick_dtlb ? dtlb_asid_i : itlb_asid_i;
                  req_dtlb_q <= pick_dtlb;
                  rr_dtlb_q  <= !pick_dtlb;
                  first_lu_q <= 1'b1;
                  kill_q     <= 1'b0;
                  state_q    <= LOOKUP;
               end
            end
            LOOKUP: begin
               first_lu_q <= 1'b0;
               if (flush_i) begin
                  kill_q <= 1'b1;
               end
               if (all_hashes_checked_i) begin
                  from_walk_q <= 1'b0;
                  err_q       <= 1'b0;
                  content_q   <= lu_content_i;
                  is_2M_q     <= lu_is_2M_i;
                  is_1G_q     <= lu_is_1G_i;
                  state_q     <= lu_hit_i ? RESP : WALK;
               end
            end
            WALK: begin
               if (flush_i) begin
                  kill_q <= 1'b1;
               end
               if (ptw_valid_i) begin
                  from_walk_q <= 1'b1;
                  err_q       <= ptw_error_i;
                  content_q   <= ptw_error_i ? '0 : ptw_content_i;
                  is_2M_q     <= ptw_is_2M_i;
                  is_1G_q     <= ptw_is_1G_i;
                  state_q     <= RESP;
               end
            end
            RESP: begin
               kill_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Response and request outputs are decoded from registered state only, and
   // are forced to zero outside the state that owns them so the buses idle
   // at zero.
   always_comb begin
      resp_fire         = (state_q == RESP) && !kill_q;
      itlb_resp_valid_o = resp_fire && !req_dtlb_q;
      dtlb_resp_valid_o = resp_fire && req_dtlb_q;
      resp_content_o    = resp_fire ? content_q : '0;
      resp_is_2M_o      = resp_fire && is_2M_q;
      resp_is_1G_o      = resp_fire && is_1G_q;
      resp_error_o      = resp_fire && err_q;
      lu_access_o       = first_lu_q;
      lu_vaddr_o        = (state_q == LOOKUP) ? vaddr_q : '0;
      lu_asid_o         = (state_q == LOOKUP) ? asid_q : '0;
      ptw_req_o         = (state_q == WALK);
      ptw_vaddr_o       = (state_q == WALK) ? vaddr_q : '0;
      ptw_asid_o        = (state_q == WALK) ? asid_q : '0;
   end

   // Refill the L2 only with a good walk result. A flush arriving in the
   // response cycle itself still lets the requester see its answer but must
   // keep the now-stale translation out of the L2.
   always_comb begin
      update_o = '0;
      if (resp_fire && from_walk_q && !err_q && !flush_i) begin
         update_o.valid                = 1'b1;
         update_o.is_2M                = is_2M_q;
         update_o.is_1G                = is_1G_q;
         update_o.vpn                  = vaddr_q[38:12];
         update_o.asid[ASID_WIDTH-1:0] = asid_q;
         update_o.content              = content_q;
      end
   end

endmodule
